cfg_mgmt_arb: RTL

- Shares the single PCIe cfg_mgmt register-access port between NUM_REQ requesters (e.g. config read/write self-test, link monitor, host-driven debug access).
- Round-robin arbitration; one transaction in flight at a time.
- Drives read/write strobes until the core returns done, then returns the result to the granted requester.
- A watchdog terminates accesses the core never completes.

---
 rtl/cfg_mgmt_arb_if.sv | 39 +++
 rtl/cfg_mgmt_arb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cfg_mgmt_arb_if.sv
// Requester and PCIe cfg_mgmt signal bundle for cfg_mgmt_arb.
// The slave modport is the arbiter; master is the requesters plus the core.
interface cfg_mgmt_arb_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ-1:0]    req_wr_i;
  logic [19*NUM_REQ-1:0] req_addr_i;
  logic [32*NUM_REQ-1:0] req_wdata_i;
  logic [4*NUM_REQ-1:0]  req_be_i;
  logic [NUM_REQ-1:0]    req_type1_i;
  logic [NUM_REQ-1:0]    rsp_valid_o;
  logic [31:0]           rsp_rdata_o;
  logic                  rsp_err_o;
  logic [18:0]           cfg_mgmt_addr_o;
  logic                  cfg_mgmt_write_o;
  logic [31:0]           cfg_mgmt_write_data_o;
  logic [3:0]            cfg_mgmt_byte_enable_o;
  logic                  cfg_mgmt_read_o;
  logic [31:0]           cfg_mgmt_read_data_i;
  logic                  cfg_mgmt_read_write_done_i;
  logic                  cfg_mgmt_type1_cfg_reg_access_o;

  modport slave (
    input  req_valid_i, req_wr_i, req_addr_i, req_wdata_i, req_be_i, req_type1_i,
    input  cfg_mgmt_read_data_i, cfg_mgmt_read_write_done_i,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output cfg_mgmt_addr_o, cfg_mgmt_write_o, cfg_mgmt_write_data_o, cfg_mgmt_byte_enable_o,
    output cfg_mgmt_read_o, cfg_mgmt_type1_cfg_reg_access_o
  );

  modport master (
    output req_valid_i, req_wr_i, req_addr_i, req_wdata_i, req_be_i, req_type1_i,
    output cfg_mgmt_read_data_i, cfg_mgmt_read_write_done_i,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  cfg_mgmt_addr_o, cfg_mgmt_write_o, cfg_mgmt_write_data_o, cfg_mgmt_byte_enable_o,
    input  cfg_mgmt_read_o, cfg_mgmt_type1_cfg_reg_access_o
  );
endinterface

// File: rtl/cfg_mgmt_arb.sv
// Round-robin arbiter sharing the PCIe cfg_mgmt port between NUM_REQ requesters, with watchdog.
// Define CFG_ARB_STAT_EN to build saturating read/write/timeout statistics counters.
module cfg_mgmt_arb #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TO_CYC  = 1024,
  parameter int unsigned TO_W    = 11
) (
  input  logic                 usr_clk,
  input  logic                 usr_rst,
  cfg_mgmt_arb_if.slave        bus,
  output logic                 busy_o,
  output logic [2:0]           grant_o,
  output logic [15:0]          rd_cnt_o,
  output logic [15:0]          wr_cnt_o,
  output logic [15:0]          to_cnt_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  localparam logic [2:0]      LastIdx = 3'(NUM_REQ - 1);
  localparam logic [TO_W-1:0] ToLast  = TO_W'(TO_CYC - 1);

  state_e               state_q, state_d;
  logic [2:0]           last_q, last_d;
  logic [TO_W-1:0]      cnt_q, cnt_d;
  logic [18:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           be_q, be_d;
  logic                 type1_q, type1_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 busy_q, busy_d;

  logic                 done;
  logic                 pick_found;
  logic [2:0]           pick_idx;
  logic                 sel_wr, sel_type1;
  logic [18:0]          sel_addr;
  logic [31:0]          sel_wdata;
  logic [3:0]           sel_be;

  assign done = bus.cfg_mgmt_read_write_done_i;

  // Rotating priority: first pending requester after last_q, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!pick_found && bus.req_valid_i[i] && (i == (32'(last_q) + off) % NUM_REQ)) begin
          pick_found = 1'b1;
          pick_idx   = 3'(i);
        end
      end
    end
  end

  always_comb begin
    sel_wr    = 1'b0;
    sel_type1 = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (3'(i) == pick_idx) begin
        sel_wr    = bus.req_wr_i[i];
        sel_type1 = bus.req_type1_i[i];
        sel_addr  = bus.req_addr_i[19*i +: 19];
        sel_wdata = bus.req_wdata_i[32*i +: 32];
        sel_be    = bus.req_be_i[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    type1_d     = type1_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          be_d    = sel_be;
          type1_d = sel_type1;
          rd_d    = ~sel_wr;
          wr_d    = sel_wr;
          last_d  = pick_idx;
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Done takes precedence over a watchdog expiry in the same cycle.
        if (done) begin
          rd_d        = 1'b0;
          wr_d        = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << last_q;
          rsp_rdata_d = rd_q ? bus.cfg_mgmt_read_data_i : 32'h0;
          state_d     = StResp;
        end else if (cnt_q == ToLast) begin
          rd_d        = 1'b0;
          wr_d        = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << last_q;
          rsp_rdata_d = 32'hFFFF_FFFF;
          rsp_err_d   = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge usr_clk) begin
    if (usr_rst) begin
      state_q     <= StIdle;
      last_q      <= LastIdx;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      type1_q     <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      type1_q     <= type1_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cfg_mgmt_addr_o                 = addr_q;
  assign bus.cfg_mgmt_write_data_o           = wdata_q;
  assign bus.cfg_mgmt_byte_enable_o          = be_q;
  assign bus.cfg_mgmt_type1_cfg_reg_access_o = type1_q;
  assign bus.cfg_mgmt_read_o                 = rd_q;
  assign bus.cfg_mgmt_write_o                = wr_q;
  assign bus.rsp_valid_o                     = rsp_valid_q;
  assign bus.rsp_rdata_o                     = rsp_rdata_q;
  assign bus.rsp_err_o                       = rsp_err_q;
  assign busy_o                              = busy_q;
  assign grant_o                             = last_q;

`ifdef CFG_ARB_STAT_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        done_hit, to_hit;

  always_comb begin
    done_hit = (state_q == StIssue) && done;
    to_hit   = (state_q == StIssue) && !done && (cnt_q == ToLast);
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    to_cnt_d = to_cnt_q;
    if (done_hit && rd_q && (rd_cnt_q != 16'hFFFF)) rd_cnt_d = rd_cnt_q + 16'd1;
    if (done_hit && wr_q && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
    if (to_hit && (to_cnt_q != 16'hFFFF))           to_cnt_d = to_cnt_q + 16'd1;
  end

  always_ff @(posedge usr_clk) begin
    if (usr_rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      to_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
  assign to_cnt_o = to_cnt_q;
`else
  assign rd_cnt_o = '0;
  assign wr_cnt_o = '0;
  assign to_cnt_o = '0;
`endif

endmodule
